reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset-release sequencer for multi-domain blocks under test and on-chip subsystems. Holds all downstream active-low resets asserted for a programmable period after reset or a restart request, then releases them one channel at a time in ascending order with a fixed gap, and pulses `done` once the last channel has settled. It replaces hand-coded `#delay`/`repeat(n) @(posedge clk)` reset stimulus with a synthesizable, cycle-exact sequence. The same block serves as a bench driver and as RTL.

## Interface
- `NUM_CH`, 4, number of reset channels (≥1).
- `HOLD_CYCLES`, 5, cycles all channels stay asserted after the start edge (≥1).
- `STEP_CYCLES`, 3, cycles between successive channel releases (≥1).
- `SETTLE_CYCLES`, 2, cycles from the last release slot to `done` (≥1).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `trigger`  in  1  restart request, level-sampled each edge.
- `ch_en`  in  NUM_CH  per-channel enable, captured at each start edge.
- `rst_n_out`  out  NUM_CH  active-low channel resets; bit k drives channel k.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse at sequence completion.
- `stage`  out  max(1,$clog2(NUM_CH))  index of the next channel to release; holds NUM_CH-1 after the last release.

## Operation
- States:
  - HOLD: all outputs asserted, counting HOLD_CYCLES.
  - STEP: one channel released per slot, STEP_CYCLES apart.
  - SETTLE: counting SETTLE_CYCLES after the last release slot.
  - IDLE: `done` already pulsed; waiting for `trigger`.
- While `rst`=1: state HOLD, counter 0, `rst_n_out`=0, `busy`=1, `done`=0, `stage`=0, captured enable cleared.
- Start edge T0:
  - T0 is either the first edge with `rst`=0, or any edge with `rst`=0 and `trigger`=1.
  - At T0: `ch_en` is captured, all `rst_n_out` go to 0, the counter is cleared, state goes to HOLD, `busy`=1, `stage`=0.
- Channel k release: `rst_n_out[k]` goes 1 after edge T0+HOLD_CYCLES+k·STEP_CYCLES, only if its captured enable is 1.
- A disabled channel stays 0 but still consumes its slot; slot timing is unchanged.
- Once released, a channel stays 1 until the next start edge or `rst`.
- `done`: high for exactly one cycle after edge T0+HOLD_CYCLES+(NUM_CH-1)·STEP_CYCLES+SETTLE_CYCLES. `busy` falls in the same cycle and the state enters IDLE.
- `trigger` at any state restarts the sequence immediately:
  - all channels re-asserted and the counter cleared;
  - no `done` is produced for the aborted sequence.
- `trigger` held high: every edge is a start edge, so the sequence never progresses.
- `trigger` in the same cycle `done` is high: restart proceeds; `done` still lasts only that one cycle.
- `ch_en` changes mid-sequence have no effect until the next start edge.
- Counter width: $clog2(max(HOLD_CYCLES,STEP_CYCLES,SETTLE_CYCLES)+1). No wrap occurs; the counter clears on every state transition.
- `rst` overrides `trigger` and every state.

## Timing
- All outputs registered; no combinational path from input to output.
- `trigger` to `rst_n_out` all 0: one edge.
- Total sequence length from T0 to `done`: HOLD_CYCLES+(NUM_CH-1)·STEP_CYCLES+SETTLE_CYCLES edges.
- NUM_CH=1: channel 0 releases at T0+HOLD_CYCLES; `done` at T0+HOLD_CYCLES+SETTLE_CYCLES.

## Test plan
- Defaults, `ch_en`=4'hF, `rst` high 3 cycles then low (T0 = first low edge) -> `rst_n_out` bits rise after T0+5, +8, +11, +14; `done` pulses once after T0+16; `busy` falls the same cycle.
- `ch_en`=4'b1010 -> bits 1 and 3 rise after T0+8 and T0+14; bits 0 and 2 stay 0; `done` still at T0+16.
- `trigger` pulse at T0+9 (channels 0 and 1 released) -> all bits 0 after that edge; new releases at +5/+8/+11/+14 from the trigger edge; exactly one `done`, 16 edges after the trigger.
- `rst` asserted at T0+12 -> all outputs at reset values next edge; sequence restarts from the first low edge.
- `trigger` coincident with `done`, and `trigger` held 4 cycles -> single-cycle `done`; the sequence restarts from the last high edge.
- NUM_CH=1, HOLD=1, STEP=1, SETTLE=1 -> bit 0 rises after T0+1; `done` after T0+2; `stage` stays 0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_CH active-low resets one at a time after a hold period.
//
// After reset, or on any edge where trigger_i is high, every channel is held in reset for
// HOLD_CYCLES. The channels are then released in ascending order, STEP_CYCLES apart.
// done_o pulses for one cycle SETTLE_CYCLES after the last release slot.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset; overrides everything
//   trigger_i    restart request, sampled on every edge
//   ch_en_i      per-channel enable, captured at each start edge
//   rst_n_out_o  active-low channel resets (bit k -> channel k)
//   busy_o       high while a sequence is running
//   done_o       one-cycle completion pulse
//   stage_o      index of the next channel to release (holds NUM_CH-1 after the last)
module reset_sequencer #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned HOLD_CYCLES   = 5,
  parameter int unsigned STEP_CYCLES   = 3,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned StageW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trigger_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic [NUM_CH-1:0] rst_n_out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [StageW-1:0] stage_o
);

  localparam int unsigned MaxHs  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned MaxCyc = (MaxHs > SETTLE_CYCLES) ? MaxHs : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [1:0] StHold   = 2'd0;
  localparam logic [1:0] StStep   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StIdle   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [StageW-1:0] stage_q, stage_d;
  // Set while in reset so the first edge after reset acts as a start edge.
  logic              start_q, start_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    stage_d = stage_q;
    start_d = 1'b0;

    if (start_q || trigger_i) begin
      state_d = StHold;
      cnt_d   = '0;
      en_d    = ch_en_i;
      rst_n_d = '0;
      busy_d  = 1'b1;
      stage_d = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            cnt_d      = '0;
            rst_n_d[0] = en_q[0];
            if (NUM_CH == 1) begin
              state_d = StSettle;
            end else begin
              state_d = StStep;
              stage_d = StageW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStep: begin
          if (cnt_q == CntW'(STEP_CYCLES - 1)) begin
            cnt_d = '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (stage_q == StageW'(k)) rst_n_d[k] = en_q[k];
            end
            // Disabled channels still consume their slot; stage parks on the last index.
            if (stage_q == StageW'(NUM_CH - 1)) begin
              state_d = StSettle;
            end else begin
              stage_d = stage_q + StageW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          // Idle: wait for trigger_i.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StHold;
      cnt_q   <= '0;
      en_q    <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      stage_q <= '0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stage_q <= stage_d;
      start_q <= start_d;
    end
  end

  assign rst_n_out_o = rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default 4-channel instance and a 1-channel, all-ones instance
// share the same stimulus. A timing model based on edges-since-start predicts every output.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic [3:0] ch_en;

  logic [3:0] rstn_a;
  logic       busy_a, done_a;
  logic [1:0] stage_a;
  logic [0:0] rstn_b;
  logic       busy_b, done_b;
  logic [0:0] stage_b;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(4), .HOLD_CYCLES(5), .STEP_CYCLES(3), .SETTLE_CYCLES(2)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .ch_en_i(ch_en),
    .rst_n_out_o(rstn_a), .busy_o(busy_a), .done_o(done_a), .stage_o(stage_a)
  );

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(1), .STEP_CYCLES(1), .SETTLE_CYCLES(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .ch_en_i(ch_en[0:0]),
    .rst_n_out_o(rstn_b), .busy_o(busy_b), .done_o(done_b), .stage_o(stage_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: edges since the last start edge, captured enables, in-reset flag.
  bit         m_valid = 0;
  bit         m_inrst = 0;
  int         m_t     = 0;
  logic [3:0] m_en    = '0;

  int         rise_a[4] = '{-1, -1, -1, -1};
  int         rise_b    = -1;
  logic [3:0] prev_a    = '0;
  logic       prev_b    = 1'b0;
  int         done_qa[$];
  int         done_qb[$];

  function automatic logic [3:0] m_rstn(int t, logic [3:0] en, int n, int h, int s);
    logic [3:0] r = '0;
    for (int k = 0; k < n; k++) r[k] = en[k] && (t >= h + k * s);
    return r;
  endfunction

  function automatic int m_stage(int t, int n, int h, int s);
    int c = 0;
    for (int k = 0; k < n; k++) if (t >= h + k * s) c++;
    return (c > n - 1) ? n - 1 : c;
  endfunction

  function automatic int cnt_from(int q[$], int lo);
    int c = 0;
    foreach (q[i]) if (q[i] >= lo) c++;
    return c;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Compare one instance against the model at the current model time.
  task automatic cmp_dut(input string name, input int n, input int h, input int s, input int se,
                         input logic [3:0] rn, input logic bz, input logic dn, input int st);
    logic [3:0] er;
    logic       eb, ed;
    int         es, total;
    total = h + (n - 1) * s + se;
    if (m_inrst) begin
      er = '0; eb = 1'b1; ed = 1'b0; es = 0;
    end else begin
      er = m_rstn(m_t, m_en, n, h, s);
      eb = (m_t < total);
      ed = (m_t == total);
      es = m_stage(m_t, n, h, s);
    end
    n_cmp++;
    if (rn !== er || bz !== eb || dn !== ed || st != es) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got rst_n=%b busy=%b done=%b stage=%0d, want rst_n=%b busy=%b done=%b stage=%0d",
               name, cyc, rn, bz, dn, st, er, eb, ed, es);
    end
  endtask

  // One clock: update the model at the edge, check and record at the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_inrst = 1; m_valid = 1;
      end else if (m_inrst || trigger) begin
        m_inrst = 0; m_t = 0; m_en = ch_en;
      end else if (m_t < 1000) begin
        m_t++;
      end
      @(negedge clk);
      if (m_valid) begin
        cmp_dut("dut_a", 4, 5, 3, 2, rstn_a, busy_a, done_a, int'(stage_a));
        cmp_dut("dut_b", 1, 1, 1, 1, {3'b000, rstn_b}, busy_b, done_b, int'(stage_b));
      end
      for (int k = 0; k < 4; k++) if (!prev_a[k] && rstn_a[k]) rise_a[k] = cyc;
      if (!prev_b && rstn_b[0]) rise_b = cyc;
      prev_a = rstn_a;
      prev_b = rstn_b[0];
      if (done_a) done_qa.push_back(cyc);
      if (done_b) done_qb.push_back(cyc);
    end
  endtask

  int s, s2;

  initial begin
    rst = 1'b1; trigger = 1'b0; ch_en = 4'hF;
    tick(3);
    chk("reset_rstn", int'(rstn_a), 0);
    chk("reset_busy", int'(busy_a), 1);

    // All channels enabled, start from reset release.
    rst = 1'b0; s = cyc + 1;
    tick(20);
    for (int k = 0; k < 4; k++) chk($sformatf("s1_rise%0d", k), rise_a[k] - s, 5 + 3 * k);
    chk("s1_done_count", cnt_from(done_qa, s), 1);
    chk("s1_done_time", done_qa[$] - s, 16);
    chk("n1_rise", rise_b - s, 1);
    chk("n1_done_time", done_qb[$] - s, 2);
    chk("s1_idle_busy", int'(busy_a), 0);

    // Sparse enables; mid-sequence ch_en change must be ignored.
    ch_en = 4'b1010; trigger = 1'b1; s = cyc + 1;
    tick(1);
    trigger = 1'b0; ch_en = 4'b0101;
    tick(19);
    chk("s2_rise1", rise_a[1] - s, 8);
    chk("s2_rise3", rise_a[3] - s, 14);
    chk("s2_bit0_quiet", int'(rise_a[0] >= s), 0);
    chk("s2_bit2_quiet", int'(rise_a[2] >= s), 0);
    chk("s2_rstn", int'(rstn_a), 4'b1010);
    chk("s2_done_time", done_qa[$] - s, 16);

    // Restart at T0+9 after channels 0 and 1 have released.
    ch_en = 4'hF; trigger = 1'b1; s = cyc + 1;
    tick(1);
    trigger = 1'b0;
    tick(8);
    chk("s3_pre_rstn", int'(rstn_a), 4'b0011);
    trigger = 1'b1; s2 = cyc + 1;
    tick(1);
    chk("s3_abort_rstn", int'(rstn_a), 0);
    trigger = 1'b0;
    tick(19);
    chk("s3_done_count", cnt_from(done_qa, s), 1);
    chk("s3_done_time", done_qa[$] - s2, 16);
    chk("s3_rise0", rise_a[0] - s2, 5);
    chk("s3_rise3", rise_a[3] - s2, 14);

    // rst at T0+12, then restart from reset release.
    trigger = 1'b1; s = cyc + 1;
    tick(1);
    trigger = 1'b0;
    tick(11);
    rst = 1'b1;
    tick(1);
    chk("s4_rst_rstn", int'(rstn_a), 0);
    chk("s4_rst_stage", int'(stage_a), 0);
    tick(1);
    rst = 1'b0; s2 = cyc + 1;
    tick(20);
    chk("s4_done_count", cnt_from(done_qa, s), 1);
    chk("s4_done_time", done_qa[$] - s2, 16);

    // Trigger while done is high, held four edges.
    trigger = 1'b1; s = cyc + 1;
    tick(1);
    trigger = 1'b0;
    tick(16);
    chk("s5_done_high", int'(done_a), 1);
    trigger = 1'b1;
    tick(4);
    s2 = cyc;
    trigger = 1'b0;
    tick(20);
    chk("s5_done_count", cnt_from(done_qa, s), 2);
    chk("s5_done_time", done_qa[$] - s2, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
